// File: rtl/game_fsm_score_if.sv
// Pong game sequencer bus: ball/button inputs in,
// game state, scores and goal strobe out.
interface game_fsm_score_if;
  logic        timing_tick;
  logic [10:0] x_ball;
  logic        start_btn;
  logic [1:0]  state;
  logic [3:0]  score_left;
  logic [3:0]  score_right;
  logic [1:0]  winner;
  logic        goal_pulse;

  modport master (
    output timing_tick, x_ball, start_btn,
    input  state, score_left, score_right,
    input  winner, goal_pulse
  );

  modport slave (
    input  timing_tick, x_ball, start_btn,
    output state, score_left, score_right,
    output winner, goal_pulse
  );
endinterface

// File: rtl/game_fsm_score.sv
// Pong game sequencer and scorekeeper: detects goals
// from x_ball, keeps scores and drives the game state.
module game_fsm_score #(
  parameter int HOR_PIXELS  = 1024,
  parameter int BALL_SIZE   = 15,
  parameter int EDGE_MARGIN = 8,
  parameter int WIN_SCORE   = 5,
  parameter int PAUSE_TICKS = 120
) (
  input  logic             clk,
  input  logic             rst,
  game_fsm_score_if.slave  bus
);

  typedef enum logic [1:0] {
    START = 2'd0,
    PLAY  = 2'd1,
    GOAL  = 2'd2,
    OVER  = 2'd3
  } state_e;

  localparam int PW = $clog2(PAUSE_TICKS + 1);
  localparam logic [10:0] X_LO =
    11'(EDGE_MARGIN);
  localparam logic [10:0] X_HI =
    11'(HOR_PIXELS - BALL_SIZE - EDGE_MARGIN);
  localparam logic [3:0] WIN = 4'(WIN_SCORE);
  localparam logic [PW-1:0] PAUSE = PW'(PAUSE_TICKS);
  localparam logic [PW-1:0] ONE = PW'(1);

  state_e          state_q, state_d;
  logic [3:0]      score_left_q, score_left_d;
  logic [3:0]      score_right_q, score_right_d;
  logic [1:0]      winner_q, winner_d;
  logic            goal_pulse_q, goal_pulse_d;
  logic [PW-1:0]   pause_cnt_q, pause_cnt_d;
  logic            start_q;

  logic            start_rise;
  logic            left_goal;
  logic            right_goal;
  logic [3:0]      sl_inc;
  logic [3:0]      sr_inc;

  assign start_rise = bus.start_btn & ~start_q;
  assign left_goal  = bus.x_ball <= X_LO;
  assign right_goal = bus.x_ball >= X_HI;

  assign sl_inc = (score_left_q < WIN) ?
                  score_left_q + 4'd1 : score_left_q;
  assign sr_inc = (score_right_q < WIN) ?
                  score_right_q + 4'd1 : score_right_q;

  // Next-state, score and pause counter logic
  always_comb begin
    state_d       = state_q;
    score_left_d  = score_left_q;
    score_right_d = score_right_q;
    winner_d      = winner_q;
    goal_pulse_d  = 1'b0;
    pause_cnt_d   = pause_cnt_q;
    unique case (state_q)
      START: begin
        score_left_d  = 4'd0;
        score_right_d = 4'd0;
        winner_d      = 2'd0;
        if (start_rise) state_d = PLAY;
      end
      PLAY: begin
        if (bus.timing_tick) begin
          if (left_goal) begin
            goal_pulse_d  = 1'b1;
            score_right_d = sr_inc;
            if (sr_inc >= WIN) begin
              state_d  = OVER;
              winner_d = 2'd2;
            end else begin
              state_d     = GOAL;
              pause_cnt_d = PAUSE;
            end
          end else if (right_goal) begin
            goal_pulse_d = 1'b1;
            score_left_d = sl_inc;
            if (sl_inc >= WIN) begin
              state_d  = OVER;
              winner_d = 2'd1;
            end else begin
              state_d     = GOAL;
              pause_cnt_d = PAUSE;
            end
          end
        end
      end
      GOAL: begin
        if (bus.timing_tick) begin
          if (pause_cnt_q <= ONE) begin
            state_d     = PLAY;
            pause_cnt_d = '0;
          end else begin
            pause_cnt_d = pause_cnt_q - ONE;
          end
        end
      end
      OVER: begin
        if (start_rise) begin
          state_d       = START;
          score_left_d  = 4'd0;
          score_right_d = 4'd0;
          winner_d      = 2'd0;
        end
      end
    endcase
  end

  // Register state; the button history keeps sampling
  // through reset so a held button is not a fresh press.
  always_ff @(posedge clk) begin
    start_q <= bus.start_btn;
    if (rst) begin
      state_q       <= START;
      score_left_q  <= 4'd0;
      score_right_q <= 4'd0;
      winner_q      <= 2'd0;
      goal_pulse_q  <= 1'b0;
      pause_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      score_left_q  <= score_left_d;
      score_right_q <= score_right_d;
      winner_q      <= winner_d;
      goal_pulse_q  <= goal_pulse_d;
      pause_cnt_q   <= pause_cnt_d;
    end
  end

  assign bus.state       = state_q;
  assign bus.score_left  = score_left_q;
  assign bus.score_right = score_right_q;
  assign bus.winner      = winner_q;
  assign bus.goal_pulse  = goal_pulse_q;

endmodule

// File: tb/tb_game_fsm_score.sv
// Bench for game_fsm_score: directed scenarios plus
// random play, checked against a rule-level model.
module tb_game_fsm_score;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  game_fsm_score_if bus ();

  game_fsm_score dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: game rules in plain integers
  int m_state = 0;
  int m_sl    = 0;
  int m_sr    = 0;
  int m_win   = 0;
  int m_pause = 0;
  int m_pulse = 0;
  bit m_prev  = 1'b0;

  task automatic award(input int who);
    m_pulse = 1;
    if (who == 1) m_sl++;
    else m_sr++;
    if ((who == 1 ? m_sl : m_sr) == 5) begin
      m_state = 3;
      m_win   = who;
    end else begin
      m_state = 2;
      m_pause = 120;
    end
  endtask

  task automatic model_clk();
    int  x;
    bit  rise;
    x = int'(bus.x_ball);
    if (rst) begin
      m_state = 0; m_sl = 0; m_sr = 0;
      m_win = 0; m_pulse = 0; m_pause = 0;
      m_prev = bus.start_btn;
      return;
    end
    rise = bus.start_btn && !m_prev;
    m_prev = bus.start_btn;
    m_pulse = 0;
    case (m_state)
      0: if (rise) m_state = 1;
      1: if (bus.timing_tick) begin
        if (x <= 8) award(2);
        else if (x >= 1001) award(1);
      end
      2: if (bus.timing_tick) begin
        m_pause--;
        if (m_pause == 0) m_state = 1;
      end
      default: if (rise) begin
        m_state = 0; m_sl = 0;
        m_sr = 0; m_win = 0;
      end
    endcase
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%0d exp=%0d",
             tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_clk();
    #1;
    chk("state", 32'(bus.state), m_state);
    chk("score_l", 32'(bus.score_left), m_sl);
    chk("score_r", 32'(bus.score_right), m_sr);
    chk("winner", 32'(bus.winner), m_win);
    chk("pulse", 32'(bus.goal_pulse), m_pulse);
  endtask

  task automatic cyc(input bit t, input int x,
                     input bit b);
    logic [31:0] xv;
    xv = x;
    bus.timing_tick = t;
    bus.x_ball      = xv[10:0];
    bus.start_btn   = b;
    step();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 512, 1'b0);
  endtask

  initial begin
    int r;
    int x;
    bus.timing_tick = 1'b0;
    bus.x_ball      = 11'd512;
    bus.start_btn   = 1'b0;

    rst = 1'b1;
    cyc(0, 512, 0);
    cyc(0, 512, 0);
    chk("rst_state", 32'(bus.state), 0);
    chk("rst_pulse", 32'(bus.goal_pulse), 0);
    rst = 1'b0;

    cyc(0, 512, 0);
    chk("t1_idle", 32'(bus.state), 0);
    cyc(0, 512, 1);
    chk("t1_play", 32'(bus.state), 1);
    cyc(0, 512, 0);

    cyc(1, 8, 0);
    chk("t2_sr", 32'(bus.score_right), 1);
    chk("t2_pulse", 32'(bus.goal_pulse), 1);
    chk("t2_goal", 32'(bus.state), 2);
    cyc(0, 512, 0);
    chk("t2_pulse0", 32'(bus.goal_pulse), 0);
    ticks(119);
    chk("t2_wait", 32'(bus.state), 2);
    ticks(1);
    chk("t2_back", 32'(bus.state), 1);

    cyc(1, 1001, 0);
    chk("t3_sl", 32'(bus.score_left), 1);
    ticks(120);
    chk("t3_back", 32'(bus.state), 1);
    cyc(1, 1000, 0);
    cyc(1, 9, 0);
    chk("t3_nosl", 32'(bus.score_left), 1);
    chk("t3_nosr", 32'(bus.score_right), 1);

    for (int i = 0; i < 100; i++) cyc(0, 5, 0);
    chk("t4_hold", 32'(bus.score_right), 1);
    cyc(1, 5, 0);
    chk("t4_one", 32'(bus.score_right), 2);
    cyc(1, 5, 0);
    chk("t4_once", 32'(bus.score_right), 2);
    ticks(119);

    for (int i = 0; i < 6000; i++) begin
      r = int'($urandom % 4);
      case (r)
        0: x = int'($urandom_range(0, 8));
        1: x = int'($urandom_range(1001, 2047));
        2: x = int'($urandom_range(9, 1000));
        default: x = int'($urandom % 2048);
      endcase
      rst = ($urandom % 700) == 0;
      cyc(bit'($urandom % 2), x,
          bit'(($urandom % 16) == 0));
    end
    rst = 1'b0;

    rst = 1'b1;
    cyc(0, 512, 0);
    rst = 1'b0;
    cyc(0, 512, 0);
    cyc(0, 512, 1);
    cyc(0, 512, 0);
    chk("t5_play", 32'(bus.state), 1);
    for (int g = 1; g <= 5; g++) begin
      cyc(1, 1001 + g * 100, 0);
      if (g < 5) ticks(120);
    end
    chk("t5_over", 32'(bus.state), 3);
    chk("t5_win", 32'(bus.winner), 1);
    chk("t5_sl", 32'(bus.score_left), 5);
    chk("t5_sr", 32'(bus.score_right), 0);
    cyc(0, 512, 0);
    cyc(0, 512, 1);
    chk("t5_start", 32'(bus.state), 0);
    chk("t5_clr", 32'(bus.score_left), 0);
    chk("t5_wclr", 32'(bus.winner), 0);

    cyc(0, 512, 0);
    cyc(0, 512, 1);
    cyc(0, 512, 0);
    cyc(1, 3, 0);
    chk("t6_goal", 32'(bus.state), 2);
    ticks(60);
    rst = 1'b1;
    cyc(0, 512, 1);
    chk("t6_state", 32'(bus.state), 0);
    chk("t6_sr", 32'(bus.score_right), 0);
    chk("t6_pulse", 32'(bus.goal_pulse), 0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) cyc(1, 512, 1);
    chk("t6_held", 32'(bus.state), 0);
    cyc(0, 512, 0);
    cyc(0, 512, 1);
    chk("t6_rise", 32'(bus.state), 1);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
